// File: rtl/triangle_setup.sv
// triangle_setup
//   Turns three screen-space vertices into the edge-function coefficients a
//   rasterizer needs. Each edge is E(x,y) = A*x + B*y + C. The coefficients
//   are oriented so that pixels inside the triangle give positive values on
//   all three edges. A bounding box is produced alongside the coefficients.
//
//   Build option TRI_SETUP_BBOX_EN:
//     defined   - the bbox is the vertex min/max, clamped to the window.
//     undefined - the bbox is the full window and no comparators are built.
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous active-low reset
//   vertex_{a,b,c}_in     x = [15:0], y = [31:16], both signed; [63:32] unused
//   win_size_in           width = [15:0], height = [31:16], unsigned
//   control_status_in     status word from the register file
//                         (bit0 START, bit1 BUSY, bit2 DONE, bit3 DEGEN)
//   status_out            status word written back to the register file
//   status_load           one-cycle write strobe for status_out
//   edge_a, edge_b        3 x signed 17-bit coefficients {e2, e1, e0}
//   edge_c                3 x signed 33-bit coefficients {e2, e1, e0}
//   bbox                  {ymax, xmax, ymin, xmin}, 16 bits each
//   setup_valid           coefficients and bbox are valid
//   setup_ready           the rasterizer accepts the setup (with setup_valid)
module triangle_setup (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] vertex_a_in,
  input  logic [63:0] vertex_b_in,
  input  logic [63:0] vertex_c_in,
  input  logic [63:0] win_size_in,
  input  logic [63:0] control_status_in,
  output logic [63:0] status_out,
  output logic        status_load,
  output logic [50:0] edge_a,
  output logic [50:0] edge_b,
  output logic [98:0] edge_c,
  output logic [63:0] bbox,
  output logic        setup_valid,
  input  logic        setup_ready
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_SUM  = 3'd2,
    ST_OUT  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  // Captured operands
  logic [15:0] x0_r, y0_r, x1_r, y1_r, x2_r, y2_r;
  logic [15:0] win_w_r, win_h_r;

  // Product sequencing and C accumulation
  logic [2:0]  cnt_r;
  logic [15:0] mul_a_s, mul_b_s;
  logic [31:0] prod_s;
  logic [32:0] prod_ext_s;
  logic [32:0] c0_r, c1_r, c2_r;

  // Orientation
  logic [34:0] area_s;
  logic        area_zero_s;
  logic        neg_r;

  // Raw (un-oriented) A/B terms
  logic [16:0] a0_s, a1_s, a2_s;
  logic [16:0] b0_s, b1_s, b2_s;

  logic [63:0] bbox_calc_s;
  logic [63:0] bbox_int_r;

  // Registered outputs
  logic [63:0] status_out_r;
  logic        status_load_r;
  logic [50:0] edge_a_r, edge_b_r;
  logic [98:0] edge_c_r;
  logic [63:0] bbox_r;
  logic        setup_valid_r;

  logic        unused_s;

  assign unused_s = ^{vertex_a_in[63:32], vertex_b_in[63:32],
                      vertex_c_in[63:32], win_size_in[63:32]};

  // Status word written when a setup is launched.
  function automatic logic [63:0] status_start_f(input logic [63:0] cs);
    return {cs[63:4], cs[3], 1'b0, 1'b1, 1'b0};
  endfunction

  // Status word written when a setup finishes.
  // START is passed through, so a START the host wrote while busy survives.
  function automatic logic [63:0] status_done_f(input logic [63:0] cs,
                                                input logic        degen);
    return {cs[63:4], degen, 1'b1, 1'b0, cs[0]};
  endfunction

  function automatic logic [16:0] neg17_f(input logic [16:0] v, input logic n);
    return n ? (~v + 17'd1) : v;
  endfunction

  function automatic logic [32:0] neg33_f(input logic [32:0] v, input logic n);
    return n ? (~v + 33'd1) : v;
  endfunction

`ifdef TRI_SETUP_BBOX_EN
  function automatic logic signed [15:0] min3_f(input logic signed [15:0] p,
                                                input logic signed [15:0] q,
                                                input logic signed [15:0] r);
    logic signed [15:0] m;
    m = (p < q) ? p : q;
    return (r < m) ? r : m;
  endfunction

  function automatic logic signed [15:0] max3_f(input logic signed [15:0] p,
                                                input logic signed [15:0] q,
                                                input logic signed [15:0] r);
    logic signed [15:0] m;
    m = (p > q) ? p : q;
    return (r > m) ? r : m;
  endfunction

  // Clamps a signed coordinate into [0, size-1].
  function automatic logic [15:0] clamp_f(input logic signed [15:0] v,
                                          input logic [15:0]        size);
    logic signed [16:0] hi;
    logic signed [16:0] vv;
    hi = $signed({1'b0, size}) - 17'sd1;
    vv = $signed({v[15], v});
    if (vv < 17'sd0) begin
      return 16'd0;
    end else if (vv > hi) begin
      return hi[15:0];
    end else begin
      return v;
    end
  endfunction
`endif

  // Selects the operand pair for the current product.
  // Each edge needs two products, first x0*y1 and then x1*y0.
  always_comb begin
    mul_a_s = 16'd0;
    mul_b_s = 16'd0;
    case (cnt_r)
      3'd0:    begin mul_a_s = x0_r; mul_b_s = y1_r; end
      3'd1:    begin mul_a_s = x1_r; mul_b_s = y0_r; end
      3'd2:    begin mul_a_s = x1_r; mul_b_s = y2_r; end
      3'd3:    begin mul_a_s = x2_r; mul_b_s = y1_r; end
      3'd4:    begin mul_a_s = x2_r; mul_b_s = y0_r; end
      3'd5:    begin mul_a_s = x0_r; mul_b_s = y2_r; end
      default: begin mul_a_s = 16'd0; mul_b_s = 16'd0; end
    endcase
  end

  assign prod_s     = $signed({{16{mul_a_s[15]}}, mul_a_s}) *
                      $signed({{16{mul_b_s[15]}}, mul_b_s});
  assign prod_ext_s = {prod_s[31], prod_s};

  assign area_s      = {{2{c0_r[32]}}, c0_r} + {{2{c1_r[32]}}, c1_r} +
                       {{2{c2_r[32]}}, c2_r};
  assign area_zero_s = (area_s == 35'd0);

  assign a0_s = {y0_r[15], y0_r} - {y1_r[15], y1_r};
  assign a1_s = {y1_r[15], y1_r} - {y2_r[15], y2_r};
  assign a2_s = {y2_r[15], y2_r} - {y0_r[15], y0_r};
  assign b0_s = {x1_r[15], x1_r} - {x0_r[15], x0_r};
  assign b1_s = {x2_r[15], x2_r} - {x1_r[15], x1_r};
  assign b2_s = {x0_r[15], x0_r} - {x2_r[15], x2_r};

  // Computes the bounding box: clamped vertex extent, or the full window.
  always_comb begin
    bbox_calc_s = 64'd0;
`ifdef TRI_SETUP_BBOX_EN
    bbox_calc_s = {clamp_f(max3_f(y0_r, y1_r, y2_r), win_h_r),
                   clamp_f(max3_f(x0_r, x1_r, x2_r), win_w_r),
                   clamp_f(min3_f(y0_r, y1_r, y2_r), win_h_r),
                   clamp_f(min3_f(x0_r, x1_r, x2_r), win_w_r)};
`else
    bbox_calc_s = {win_h_r - 16'd1, win_w_r - 16'd1, 16'd0, 16'd0};
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (control_status_in[0]) state_nxt_s = ST_MUL;
        else                      state_nxt_s = ST_IDLE;
      end
      ST_MUL: begin
        if (cnt_r == 3'd5) state_nxt_s = ST_SUM;
        else               state_nxt_s = ST_MUL;
      end
      ST_SUM: begin
        if (area_zero_s) state_nxt_s = ST_WB;
        else             state_nxt_s = ST_OUT;
      end
      ST_OUT: begin
        if (setup_valid_r && setup_ready) state_nxt_s = ST_WB;
        else                              state_nxt_s = ST_OUT;
      end
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath: operand capture, product accumulation, orientation and outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0_r <= 16'd0; y0_r <= 16'd0;
      x1_r <= 16'd0; y1_r <= 16'd0;
      x2_r <= 16'd0; y2_r <= 16'd0;
      win_w_r       <= 16'd0;
      win_h_r       <= 16'd0;
      cnt_r         <= 3'd0;
      c0_r          <= 33'd0;
      c1_r          <= 33'd0;
      c2_r          <= 33'd0;
      neg_r         <= 1'b0;
      bbox_int_r    <= 64'd0;
      status_out_r  <= 64'd0;
      status_load_r <= 1'b0;
      edge_a_r      <= 51'd0;
      edge_b_r      <= 51'd0;
      edge_c_r      <= 99'd0;
      bbox_r        <= 64'd0;
      setup_valid_r <= 1'b0;
    end else begin
      status_load_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (control_status_in[0]) begin
            x0_r          <= vertex_a_in[15:0];
            y0_r          <= vertex_a_in[31:16];
            x1_r          <= vertex_b_in[15:0];
            y1_r          <= vertex_b_in[31:16];
            x2_r          <= vertex_c_in[15:0];
            y2_r          <= vertex_c_in[31:16];
            win_w_r       <= win_size_in[15:0];
            win_h_r       <= win_size_in[31:16];
            cnt_r         <= 3'd0;
            neg_r         <= 1'b0;
            status_out_r  <= status_start_f(control_status_in);
            status_load_r <= 1'b1;
          end
        end
        ST_MUL: begin
          cnt_r <= (cnt_r == 3'd5) ? 3'd0 : cnt_r + 3'd1;
          case (cnt_r)
            3'd0:    c0_r <= prod_ext_s;
            3'd1:    c0_r <= c0_r - prod_ext_s;
            3'd2:    c1_r <= prod_ext_s;
            3'd3:    c1_r <= c1_r - prod_ext_s;
            3'd4:    c2_r <= prod_ext_s;
            3'd5:    c2_r <= c2_r - prod_ext_s;
            default: c0_r <= c0_r;
          endcase
        end
        ST_SUM: begin
          // A clockwise triangle has a negative area. Flipping every
          // coefficient then makes interior pixels evaluate positive.
          neg_r      <= area_s[34];
          bbox_int_r <= bbox_calc_s;
          if (area_zero_s) begin
            status_out_r  <= status_done_f(control_status_in, 1'b1);
            status_load_r <= 1'b1;
          end
        end
        ST_OUT: begin
          // The first OUT cycle loads the outputs. Ready is only honoured
          // once valid is already up.
          if (!setup_valid_r) begin
            edge_a_r <= {neg17_f(a2_s, neg_r), neg17_f(a1_s, neg_r),
                         neg17_f(a0_s, neg_r)};
            edge_b_r <= {neg17_f(b2_s, neg_r), neg17_f(b1_s, neg_r),
                         neg17_f(b0_s, neg_r)};
            edge_c_r <= {neg33_f(c2_r, neg_r), neg33_f(c1_r, neg_r),
                         neg33_f(c0_r, neg_r)};
            bbox_r        <= bbox_int_r;
            setup_valid_r <= 1'b1;
          end else if (setup_ready) begin
            setup_valid_r <= 1'b0;
            status_out_r  <= status_done_f(control_status_in, 1'b0);
            status_load_r <= 1'b1;
          end
        end
        ST_WB: begin
          cnt_r <= 3'd0;
        end
        default: begin
          cnt_r <= 3'd0;
        end
      endcase
    end
  end

  assign status_out  = status_out_r;
  assign status_load = status_load_r;
  assign edge_a      = edge_a_r;
  assign edge_b      = edge_b_r;
  assign edge_c      = edge_c_r;
  assign bbox        = bbox_r;
  assign setup_valid = setup_valid_r;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed self-checking bench for triangle_setup.
// The bench models the register file itself: status_load writes status_out
// into ctrl, and the host can set START in ctrl.
module tb_triangle_setup;

  localparam logic [63:0] CTRL_INIT = 64'hA5A5_0000_1234_0000;
  localparam int          WAIT_MAX  = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] vertex_a, vertex_b, vertex_c, win_size, ctrl;
  logic [63:0] status_out;
  logic        status_load;
  logic [50:0] edge_a, edge_b;
  logic [98:0] edge_c;
  logic [63:0] bbox;
  logic        setup_valid;
  logic        setup_ready;
  logic        host_start, host_clr;

  int checks   = 0;
  int failures = 0;
  int ld_cnt   = 0;
  int wb_cnt   = 0;

  triangle_setup dut (
    .clk               (clk),
    .reset             (reset),
    .vertex_a_in       (vertex_a),
    .vertex_b_in       (vertex_b),
    .vertex_c_in       (vertex_c),
    .win_size_in       (win_size),
    .control_status_in (ctrl),
    .status_out        (status_out),
    .status_load       (status_load),
    .edge_a            (edge_a),
    .edge_b            (edge_b),
    .edge_c            (edge_c),
    .bbox              (bbox),
    .setup_valid       (setup_valid),
    .setup_ready       (setup_ready)
  );

  always #5 clk = ~clk;

  // Register file model; it has its own reset (host_clr).
  always @(posedge clk) begin
    if (host_clr)                  ctrl <= CTRL_INIT;
    else if (status_load === 1'b1) ctrl <= status_out;
    else if (host_start)           ctrl <= ctrl | 64'd1;
  end

  // Counts every status write and every write-back (DONE set).
  always @(posedge clk) begin
    if (status_load === 1'b1) ld_cnt <= ld_cnt + 1;
    if (status_load === 1'b1 && status_out[2] === 1'b1) wb_cnt <= wb_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] vtx(input int x, input int y);
    return {32'd0, y[15:0], x[15:0]};
  endfunction

  function automatic logic [50:0] pack17(input int e2, input int e1, input int e0);
    return {e2[16:0], e1[16:0], e0[16:0]};
  endfunction

  function automatic logic [98:0] pack33(input longint e2, input longint e1,
                                         input longint e0);
    return {e2[32:0], e1[32:0], e0[32:0]};
  endfunction

  // The host writes START, then the bench waits for the launch edge.
  // lat counts the edges from the launch edge until setup_valid is seen,
  // capped at WAIT_MAX.
  task automatic run_one(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input string nm, output int lat);
    logic [63:0] exp_st;
    vertex_a = a; vertex_b = b; vertex_c = c;
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
    exp_st = {ctrl[63:4], ctrl[3], 3'b010};
    @(posedge clk); #1;
    check({nm, "_start_load"}, status_load, 1'b1);
    check({nm, "_start_status"}, status_out, exp_st);
    lat = 0;
    while (setup_valid !== 1'b1 && lat < WAIT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int lat, n, ld0, wb0, unstable;
    logic [50:0] snap_a, snap_b;
    logic [98:0] snap_c;
    logic [63:0] snap_bb;
    int ev;

    reset = 1'b0; setup_ready = 1'b0; host_start = 1'b0; host_clr = 1'b1;
    vertex_a = 64'd0; vertex_b = 64'd0; vertex_c = 64'd0;
    win_size = {32'd0, 16'd48, 16'd64};
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", setup_valid, 1'b0);
    check("rst_load", status_load, 1'b0);
    check("rst_status", status_out, 64'd0);
    check("rst_edge_a", edge_a, 51'd0);
    check("rst_edge_c", edge_c, 99'd0);
    check("rst_bbox", bbox, 64'd0);
    host_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // V-1: counter-clockwise triangle, ready held high.
    setup_ready = 1'b1;
    ld0 = ld_cnt; wb0 = wb_cnt;
    run_one(vtx(0, 0), vtx(10, 0), vtx(0, 10), "v1", lat);
    check("v1_latency", lat, 8);
    check("v1_edge_a", edge_a, pack17(10, -10, 0));
    check("v1_edge_b", edge_b, pack17(0, -10, 10));
    check("v1_edge_c", edge_c, pack33(0, 100, 0));
    @(posedge clk); #1;
    check("v1_wb_load", status_load, 1'b1);
    check("v1_wb_bits", status_out[3:0], 4'b0100);
    check("v1_wb_upper", status_out[63:4], CTRL_INIT[63:4]);
    repeat (3) @(posedge clk);
    #1;
    check("v1_valid_drop", setup_valid, 1'b0);
    check("v1_load_count", ld_cnt - ld0, 2);
    check("v1_wb_count", wb_cnt - wb0, 1);

    // V-2: clockwise triangle; the raw coefficients come out negated.
    run_one(vtx(0, 0), vtx(0, 10), vtx(10, 0), "v2", lat);
    check("v2_latency", lat, 8);
    check("v2_edge_a", edge_a, pack17(0, -10, 10));
    check("v2_edge_b", edge_b, pack17(10, -10, 0));
    check("v2_edge_c", edge_c, pack33(0, 100, 0));
    for (int i = 0; i < 3; i++) begin
      ev = int'($signed(edge_a[17*i +: 17])) * 2 +
           int'($signed(edge_b[17*i +: 17])) * 3 +
           int'($signed(edge_c[33*i +: 33]));
      check($sformatf("v2_inside_e%0d", i), (ev > 0), 1'b1);
    end
    repeat (4) @(posedge clk);
    #1;

    // V-3: collinear vertices; no valid, degenerate write-back.
    ld0 = ld_cnt; wb0 = wb_cnt;
    run_one(vtx(0, 0), vtx(5, 5), vtx(10, 10), "v3", lat);
    check("v3_never_valid", lat, WAIT_MAX);
    check("v3_status_bits", ctrl[3:0], 4'b1100);
    check("v3_load_count", ld_cnt - ld0, 2);
    check("v3_wb_count", wb_cnt - wb0, 1);

    // V-4: ready held low; outputs must hold until the handshake.
    setup_ready = 1'b0;
    wb0 = wb_cnt;
    run_one(vtx(1, 2), vtx(30, 4), vtx(8, 25), "v4", lat);
    check("v4_latency", lat, 8);
    check("v4_edge_a", edge_a, pack17(23, -21, -2));
    check("v4_edge_b", edge_b, pack17(-7, -22, 29));
    check("v4_edge_c", edge_c, pack33(-9, 718, -56));
    snap_a = edge_a; snap_b = edge_b; snap_c = edge_c; snap_bb = bbox;
    unstable = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (edge_a !== snap_a || edge_b !== snap_b || edge_c !== snap_c ||
          bbox !== snap_bb || setup_valid !== 1'b1 || status_load !== 1'b0)
        unstable++;
    end
    check("v4_hold_stable", unstable, 0);
    setup_ready = 1'b1;
    @(posedge clk); #1;
    setup_ready = 1'b0;
    check("v4_wb_load", status_load, 1'b1);
    check("v4_wb_done", status_out[2], 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("v4_wb_once", wb_cnt - wb0, 1);
    check("v4_valid_drop", setup_valid, 1'b0);

    // V-6: vertices partly outside a 64x48 window.
    setup_ready = 1'b1;
    run_one(vtx(-5, 3), vtx(70, 10), vtx(20, 60), "v6", lat);
    check("v6_latency", lat, 8);
    check("v6_edge_a", edge_a, pack17(57, -50, -7));
    check("v6_edge_c", edge_c, pack33(360, 4000, -260));
`ifdef TRI_SETUP_BBOX_EN
    check("v6_bbox", bbox, {16'd47, 16'd63, 16'd3, 16'd0});
`else
    check("v6_bbox", bbox, {16'd47, 16'd63, 16'd0, 16'd0});
`endif
    repeat (4) @(posedge clk);
    #1;

    // V-5: START rewritten during MUL, then reset during a later MUL.
    wb0 = wb_cnt;
    vertex_a = vtx(0, 0); vertex_b = vtx(10, 0); vertex_c = vtx(0, 10);
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
    @(posedge clk); #1;
    check("v5_start1_load", status_load, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
    n = 0;
    while (!(status_load === 1'b1 && status_out[2] === 1'b1) && n < WAIT_MAX) begin
      @(posedge clk); #1;
      n++;
    end
    check("v5_wb1_start_kept", status_out[0], 1'b1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(status_load === 1'b1 && status_out[1] === 1'b1) && n < WAIT_MAX);
    check("v5_restart_gap", n, 2);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("v5_rst_valid", setup_valid, 1'b0);
    check("v5_rst_load", status_load, 1'b0);
    check("v5_rst_status", status_out, 64'd0);
    check("v5_rst_edge_a", edge_a, 51'd0);
    check("v5_rst_edge_b", edge_b, 51'd0);
    check("v5_rst_edge_c", edge_c, 99'd0);
    check("v5_rst_bbox", bbox, 64'd0);
    ld0 = ld_cnt;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("v5_no_wb_after_rst", wb_cnt - wb0, 1);
    check("v5_idle_no_load", ld_cnt - ld0, 0);
    check("v5_idle_no_valid", setup_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
